hwpe_ctrl_periph_arbiter: RTL and testbench
===========================================

HWPE_CTRL_PERIPH_ARBITER -- requirements
Module: hwpe_ctrl_periph_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of upstream requesters (cores), 2..16.
REQ-002 SHALL have parameter ID_WIDTH, default 16: peripheral transaction id width.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1024: idle cycles before a held lock is force-released; range 1..65535.
REQ-004 SHALL have the clock port, named clk_i: 1 bit, the only clock; everything is sampled on its rising edge.
REQ-005 SHALL have the reset port, named rst_i: 1 bit, asynchronous, active-high.
REQ-006 SHALL have clear_i: input, 1 bit, synchronous soft clear (the control slave's clear_o).
REQ-007 SHALL have up_req_i, up_wen_i: inputs, N_REQ bits each; request and write-not-enable (1=read) per requester.
REQ-008 SHALL have up_add_i, up_data_i: inputs, N_REQ x 32 each; address and write data.
REQ-009 SHALL have up_be_i: input, N_REQ x 4; byte enables.
REQ-010 SHALL have up_id_i: input, N_REQ x ID_WIDTH; transaction id.
REQ-011 SHALL have up_gnt_o and up_r_valid_o: outputs, N_REQ bits each.
REQ-012 SHALL have up_r_data_o: output, 32 bits, broadcast to all requesters; up_r_id_o: output, ID_WIDTH bits, broadcast.
REQ-013 SHALL have slv_req_o, slv_wen_o (1 bit), slv_add_o, slv_data_o (32), slv_be_o (4) and slv_id_o (ID_WIDTH): outputs toward the control slave.
REQ-014 SHALL have slv_gnt_i, slv_r_valid_i (1 bit), slv_r_data_i (32) and slv_r_id_i (ID_WIDTH): inputs from the control slave.
REQ-015 SHALL have locked_o (1 bit), lock_owner_o ($clog2(N_REQ) bits) and timeout_o (1 bit): outputs.

Function
REQ-016 SHALL compute the register index as up_add[LOG_REGS+1:2], with LOG_REGS = $clog2(REGFILE_N_REGISTERS).
- Index 0 + write = trigger.
- Index 1 + read = acquire (test&set).
REQ-017 SHALL arbitrate round-robin in IDLE state.
- Winner: first requester with up_req_i set, searching upward from rr_ptr with wrap.
- Selection is combinational: zero-cycle grant.
REQ-018 SHALL mux the winner's add/wen/data/be/id onto slv_*.
- slv_req_o = any winner.
- up_gnt_o[winner] = slv_gnt_i; all other up_gnt_o bits 0.
REQ-019 SHALL, on a granted transfer (slv_req_o & slv_gnt_i) by requester k, set rr_ptr <= (k+1) mod N_REQ; otherwise rr_ptr holds.
REQ-020 SHALL support one outstanding response.
- On a granted transfer, register resp_owner <= k and resp_acq <= (read & index 1).
- On slv_r_valid_i: up_r_valid_o[resp_owner] = 1 and all other bits 0.
- up_r_data_o = slv_r_data_i and up_r_id_o = slv_r_id_i, combinationally.
REQ-021 SHALL run a lock FSM with states IDLE and LOCKED.
- IDLE -> LOCKED: slv_r_valid_i & resp_acq & slv_r_data_i[31]==0 (acquire succeeded); owner <= resp_owner.
- A negative acquire response leaves the FSM in IDLE.
REQ-022 SHALL, in LOCKED, consider only the owner's up_req_i; up_gnt_o of all other requesters SHALL be 0.
REQ-023 SHALL leave LOCKED for IDLE on the cycle after a granted owner trigger write; the trigger itself is forwarded.
REQ-024 SHALL count cycles in LOCKED without an owner request.
- Counter width $clog2(LOCK_TIMEOUT+1); it resets to 0 on any owner request.
- When the count reaches LOCK_TIMEOUT: go to IDLE and pulse timeout_o for exactly 1 cycle.
REQ-025 SHALL resolve simultaneous events as follows:
- Owner trigger in the same cycle as timeout: the trigger wins and timeout_o stays 0.
- Acquire response arriving in the same cycle as a new grant: lock applies from the next cycle.
REQ-026 SHALL drive locked_o = (state==LOCKED) and lock_owner_o = owner (0 in IDLE).
REQ-027 SHALL, on clear_i, next cycle set: state IDLE, rr_ptr 0, counter 0, resp_acq 0 and timeout_o 0; a response already in flight is still routed.

Reset
REQ-028 SHALL, while rst_i=1, force:
- state IDLE, rr_ptr 0, owner 0, resp_owner 0, resp_acq 0, counter 0;
- timeout_o 0, locked_o 0, lock_owner_o 0.
REQ-029 SHALL keep all up_gnt_o, up_r_valid_o and slv_req_o at 0 while rst_i=1.

Structure
REQ-030 SHALL take REGFILE_N_REGISTERS and the trigger/acquire register indices from hwpe_ctrl_package; the lock state enum SHALL be added there as a typedef.
REQ-031 SHALL instantiate one sub-module, hwpe_ctrl_rr_picker: combinational N_REQ-way round-robin find-first from a pointer, returning a onehot vector plus an index.

Verification
REQ-032 SHALL cover: N_REQ=4, all four requesting continuously reads of index 3, slv_gnt_i=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover: requester 2 acquires and the response is 0x0 -> locked_o=1 and lock_owner_o=2; requesters 0/1/3 get no grant until requester 2 writes index 0; locked_o=0 one cycle after that write.
REQ-034 SHALL cover: acquire response 0xFFFFFFFF -> locked_o stays 0 and round-robin continues.
REQ-035 SHALL cover: LOCK_TIMEOUT=8, lock held with the owner silent -> timeout_o pulses 1 cycle on the 8th idle cycle, then other requesters are granted.
REQ-036 SHALL cover: rst_i asserted asynchronously mid-LOCKED -> all outputs 0 immediately; after release the first grant goes to requester 0.
REQ-037 SHALL cover: clear_i pulse while LOCKED with a response in flight -> that response is delivered to the correct requester; state is IDLE next cycle.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// rtl/hwpe_ctrl_package.sv - register map constants and lock state type for the hwpe control slice
package hwpe_ctrl_package;

  localparam int unsigned REGFILE_N_REGISTERS = 64;
  localparam int unsigned REGFILE_LOG_REGS    = $clog2(REGFILE_N_REGISTERS);
  localparam int unsigned REGFILE_IDX_TRIGGER = 0;
  localparam int unsigned REGFILE_IDX_ACQUIRE = 1;

  typedef enum logic [0:0] {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_t;

  function automatic logic [REGFILE_LOG_REGS-1:0] reg_index(input logic [31:0] add);
    return add[REGFILE_LOG_REGS+1:2];
  endfunction

endpackage

// File: rtl/hwpe_ctrl_periph_arbiter_if.sv
// rtl/hwpe_ctrl_periph_arbiter_if.sv - upstream requester and control-slave peripheral bus signals
interface hwpe_ctrl_periph_arbiter_if #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_WIDTH = 16
);

  logic [N_REQ-1:0]               up_req_i;
  logic [N_REQ-1:0]               up_wen_i;
  logic [N_REQ-1:0][31:0]         up_add_i;
  logic [N_REQ-1:0][31:0]         up_data_i;
  logic [N_REQ-1:0][3:0]          up_be_i;
  logic [N_REQ-1:0][ID_WIDTH-1:0] up_id_i;
  logic [N_REQ-1:0]               up_gnt_o;
  logic [N_REQ-1:0]               up_r_valid_o;
  logic [31:0]                    up_r_data_o;
  logic [ID_WIDTH-1:0]            up_r_id_o;

  logic                           slv_req_o;
  logic                           slv_wen_o;
  logic [31:0]                    slv_add_o;
  logic [31:0]                    slv_data_o;
  logic [3:0]                     slv_be_o;
  logic [ID_WIDTH-1:0]            slv_id_o;
  logic                           slv_gnt_i;
  logic                           slv_r_valid_i;
  logic [31:0]                    slv_r_data_i;
  logic [ID_WIDTH-1:0]            slv_r_id_i;

  // arbiter side
  modport slave (
    input  up_req_i, up_wen_i, up_add_i, up_data_i, up_be_i, up_id_i,
    output up_gnt_o, up_r_valid_o, up_r_data_o, up_r_id_o,
    output slv_req_o, slv_wen_o, slv_add_o, slv_data_o, slv_be_o, slv_id_o,
    input  slv_gnt_i, slv_r_valid_i, slv_r_data_i, slv_r_id_i
  );

  // requesters plus control slave, as seen from outside the arbiter
  modport master (
    output up_req_i, up_wen_i, up_add_i, up_data_i, up_be_i, up_id_i,
    input  up_gnt_o, up_r_valid_o, up_r_data_o, up_r_id_o,
    input  slv_req_o, slv_wen_o, slv_add_o, slv_data_o, slv_be_o, slv_id_o,
    output slv_gnt_i, slv_r_valid_i, slv_r_data_i, slv_r_id_i
  );

endinterface

// File: rtl/hwpe_ctrl_rr_picker.sv
// rtl/hwpe_ctrl_rr_picker.sv - combinational round-robin find-first starting at a pointer
module hwpe_ctrl_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  always_comb begin
    int w_j;
    w_j      = 0;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_j = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[w_j]) begin
        any_o         = 1'b1;
        idx_o         = $clog2(N)'(w_j);
        onehot_o[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// rtl/hwpe_ctrl_periph_arbiter.sv - round-robin arbiter of N cores onto the control slave with a test&set lock
module hwpe_ctrl_periph_arbiter
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned ID_WIDTH     = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  hwpe_ctrl_periph_arbiter_if.slave bus,
  output logic                     locked_o,
  output logic [$clog2(N_REQ)-1:0] lock_owner_o,
  output logic                     timeout_o
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

  lock_state_t   r_state;
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] r_resp_owner;
  logic          r_resp_acq;
  logic          r_timeout;
  logic [CW-1:0] r_cnt;

  logic [N_REQ-1:0]            w_eligible;
  logic [N_REQ-1:0]            w_onehot;
  logic [PW-1:0]               w_win;
  logic                        w_any;
  logic                        w_xfer;
  logic                        w_win_read;
  logic [REGFILE_LOG_REGS-1:0] w_win_idx;
  logic                        w_owner_req;
  logic                        w_trigger;
  logic                        w_expire;
  logic                        w_acq_ok;
  logic [PW-1:0]               w_ptr_next;

  // While locked only the owner may compete; reset masks everyone so grants drop immediately.
  always_comb begin
    w_eligible = '0;
    if (!rst_i) begin
      if (r_state == LOCK_LOCKED) begin
        w_eligible[r_owner] = bus.up_req_i[r_owner];
      end else begin
        w_eligible = bus.up_req_i;
      end
    end
  end

  hwpe_ctrl_rr_picker #(
    .N (N_REQ)
  ) u_picker (
    .req_i    (w_eligible),
    .ptr_i    (r_rr_ptr),
    .onehot_o (w_onehot),
    .idx_o    (w_win),
    .any_o    (w_any)
  );

  assign w_xfer     = w_any & bus.slv_gnt_i;
  assign w_win_read = bus.up_wen_i[w_win];
  assign w_win_idx  = reg_index(bus.up_add_i[w_win]);
  assign w_ptr_next = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;

  assign bus.slv_req_o  = w_any;
  assign bus.slv_wen_o  = w_win_read;
  assign bus.slv_add_o  = bus.up_add_i[w_win];
  assign bus.slv_data_o = bus.up_data_i[w_win];
  assign bus.slv_be_o   = bus.up_be_i[w_win];
  assign bus.slv_id_o   = bus.up_id_i[w_win];
  assign bus.up_gnt_o   = w_onehot & {N_REQ{bus.slv_gnt_i}};

  always_comb begin
    bus.up_r_valid_o = '0;
    if (!rst_i && bus.slv_r_valid_i) begin
      bus.up_r_valid_o[r_resp_owner] = 1'b1;
    end
  end

  assign bus.up_r_data_o = bus.slv_r_data_i;
  assign bus.up_r_id_o   = bus.slv_r_id_i;

  assign w_owner_req = bus.up_req_i[r_owner];
  assign w_trigger   = (r_state == LOCK_LOCKED) & w_xfer & ~w_win_read
                     & (w_win_idx == REGFILE_LOG_REGS'(REGFILE_IDX_TRIGGER));
  assign w_expire    = (r_state == LOCK_LOCKED) & ~w_owner_req
                     & (r_cnt == CW'(LOCK_TIMEOUT - 1));
  // Bit 31 of the acquire read-back is the previous lock value: 0 means we took it.
  assign w_acq_ok    = (r_state == LOCK_IDLE) & bus.slv_r_valid_i & r_resp_acq
                     & ~bus.slv_r_data_i[31];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= LOCK_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_resp_owner <= '0;
      r_resp_acq   <= 1'b0;
      r_timeout    <= 1'b0;
      r_cnt        <= '0;
    end else if (clear_i) begin
      r_state    <= LOCK_IDLE;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_resp_acq <= 1'b0;
      r_timeout  <= 1'b0;
      if (w_xfer) begin
        r_resp_owner <= w_win;
      end
    end else begin
      r_timeout <= 1'b0;
      if (w_xfer) begin
        r_rr_ptr     <= w_ptr_next;
        r_resp_owner <= w_win;
        r_resp_acq   <= w_win_read & (w_win_idx == REGFILE_LOG_REGS'(REGFILE_IDX_ACQUIRE));
      end
      if (r_state == LOCK_IDLE) begin
        r_cnt <= '0;
        if (w_acq_ok) begin
          r_state <= LOCK_LOCKED;
          r_owner <= r_resp_owner;
        end
      end else if (w_trigger) begin
        r_state <= LOCK_IDLE;
        r_cnt   <= '0;
      end else if (w_owner_req) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_state   <= LOCK_IDLE;
        r_cnt     <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign locked_o     = (r_state == LOCK_LOCKED);
  assign lock_owner_o = (r_state == LOCK_LOCKED) ? r_owner : '0;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
// tb/tb_hwpe_ctrl_periph_arbiter.sv - directed and randomized checks of the peripheral arbiter against a behavioural model
module tb_hwpe_ctrl_periph_arbiter;

  localparam int N     = 4;
  localparam int IDW   = 16;
  localparam int LT    = 8;
  localparam int NREGS = hwpe_ctrl_package::REGFILE_N_REGISTERS;

  logic       clk_i   = 1'b0;
  logic       rst_i   = 1'b1;
  logic       clear_i = 1'b0;
  logic       locked_o;
  logic [1:0] lock_owner_o;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;

  hwpe_ctrl_periph_arbiter_if #(.N_REQ(N), .ID_WIDTH(IDW)) bus ();

  hwpe_ctrl_periph_arbiter #(
    .N_REQ        (N),
    .ID_WIDTH     (IDW),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .bus          (bus),
    .locked_o     (locked_o),
    .lock_owner_o (lock_owner_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a / 4) % NREGS;
  endfunction

  // Reference model: state after the next rising edge, computed from the visible inputs.
  int         m_ptr, m_owner, m_cnt, m_resp_owner, m_win, m_k;
  bit         m_locked, m_resp_acq, m_timeout, m_found, m_xfer, m_n_to;
  logic [N-1:0] m_gnt, m_rv;

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_slv_req", bus.slv_req_o, 0);
      chk("rst_gnt", bus.up_gnt_o, 0);
      chk("rst_rvalid", bus.up_r_valid_o, 0);
      chk("rst_locked", locked_o, 0);
      chk("rst_owner", lock_owner_o, 0);
      chk("rst_timeout", timeout_o, 0);
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_resp_owner = 0;
      m_locked = 0; m_resp_acq = 0; m_timeout = 0;
    end else begin
      m_found = 0; m_win = 0;
      for (int s = 0; s < N; s++) begin
        m_k = (m_ptr + s) % N;
        if (!m_found && bus.up_req_i[m_k] && (!m_locked || m_k == m_owner)) begin
          m_found = 1; m_win = m_k;
        end
      end
      m_xfer = m_found && bus.slv_gnt_i;
      m_gnt = '0; if (m_xfer) m_gnt[m_win] = 1'b1;
      m_rv  = '0; if (bus.slv_r_valid_i) m_rv[m_resp_owner] = 1'b1;
      chk("m_slv_req", bus.slv_req_o, m_found);
      chk("m_gnt", bus.up_gnt_o, m_gnt);
      chk("m_rvalid", bus.up_r_valid_o, m_rv);
      chk("m_rdata", bus.up_r_data_o, bus.slv_r_data_i);
      chk("m_rid", bus.up_r_id_o, bus.slv_r_id_i);
      chk("m_locked", locked_o, m_locked);
      chk("m_owner", lock_owner_o, m_locked ? m_owner : 0);
      chk("m_timeout", timeout_o, m_timeout);
      if (m_found) begin
        chk("m_slv_add", bus.slv_add_o, bus.up_add_i[m_win]);
        chk("m_slv_wen", bus.slv_wen_o, bus.up_wen_i[m_win]);
        chk("m_slv_data", bus.slv_data_o, bus.up_data_i[m_win]);
        chk("m_slv_be", bus.slv_be_o, bus.up_be_i[m_win]);
        chk("m_slv_id", bus.slv_id_o, bus.up_id_i[m_win]);
      end
      m_n_to = 0;
      if (m_locked) begin
        if (m_xfer && !bus.up_wen_i[m_win] && idx_of(bus.up_add_i[m_win]) == 0) begin
          m_locked = 0;
        end else if (bus.up_req_i[m_owner]) begin
          m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == LT) begin m_locked = 0; m_n_to = 1; m_cnt = 0; end
        end
      end else if (bus.slv_r_valid_i && m_resp_acq && !bus.slv_r_data_i[31]) begin
        m_locked = 1; m_owner = m_resp_owner; m_cnt = 0;
      end
      if (m_xfer) begin
        m_ptr = (m_win + 1) % N;
        m_resp_owner = m_win;
        m_resp_acq = bus.up_wen_i[m_win] && idx_of(bus.up_add_i[m_win]) == 1;
      end
      if (clear_i) begin
        m_locked = 0; m_ptr = 0; m_cnt = 0; m_resp_acq = 0; m_n_to = 0;
      end
      m_timeout = m_n_to;
    end
  end

  task automatic nc();
    @(posedge clk_i); #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic quiet();
    bus.up_req_i = '0; bus.slv_r_valid_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic put(input int k, input bit wen, input int idx);
    bus.up_wen_i[k]  = wen;
    bus.up_add_i[k]  = ($urandom & 32'hFFFF_FF00) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
    bus.up_data_i[k] = $urandom;
    bus.up_be_i[k]   = 4'($urandom);
    bus.up_id_i[k]   = 16'($urandom);
  endtask

  // Acquire cycle then response cycle; returns at the start of the cycle after the response.
  task automatic lock_by(input int k, input logic [31:0] resp);
    logic [N-1:0] one;
    one = '0; one[k] = 1'b1;
    quiet();
    put(k, 1'b1, 1);
    bus.up_req_i = one; bus.slv_gnt_i = 1'b1;
    look(); chk("acq_gnt", bus.up_gnt_o, one);
    nc();
    bus.up_req_i = '0; bus.slv_r_valid_i = 1'b1; bus.slv_r_data_i = resp;
    look(); chk("acq_rvalid", bus.up_r_valid_o, one);
    nc();
    bus.slv_r_valid_i = 1'b0;
  endtask

  logic [N-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  bit pend = 1'b0;
  int sel, ridx;
  bit rwen;

  initial begin
    bus.up_req_i = '0; bus.up_wen_i = '0; bus.up_add_i = '0; bus.up_data_i = '0;
    bus.up_be_i = '0; bus.up_id_i = '0; bus.slv_gnt_i = 1'b0; bus.slv_r_valid_i = 1'b0;
    bus.slv_r_data_i = '0; bus.slv_r_id_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    look();
    chk("reset_locked", locked_o, 0);
    chk("reset_owner", lock_owner_o, 0);
    chk("reset_timeout", timeout_o, 0);
    chk("reset_slv_req", bus.slv_req_o, 0);

    // continuous reads of index 3 from everyone: strict rotation
    nc();
    for (int k = 0; k < N; k++) put(k, 1'b1, 3);
    bus.up_req_i = 4'hF; bus.slv_gnt_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      look(); chk("rr_seq", bus.up_gnt_o, exp_rr[c]);
      nc();
      bus.slv_r_valid_i = 1'b1; bus.slv_r_data_i = $urandom;
    end
    bus.up_req_i = '0;
    nc(); quiet();

    // successful acquire by 2 blocks the others until its trigger write
    lock_by(2, 32'h0);
    for (int k = 0; k < N; k++) if (k != 2) put(k, 1'b1, 3);
    bus.up_req_i = 4'b1011;
    look(); chk("lock_locked", locked_o, 1); chk("lock_owner", lock_owner_o, 2);
    chk("lock_block_gnt", bus.up_gnt_o, 0); chk("lock_block_req", bus.slv_req_o, 0);
    for (int c = 0; c < 3; c++) begin
      nc(); look(); chk("lock_block_gnt", bus.up_gnt_o, 0);
    end
    nc();
    put(2, 1'b0, 0); bus.up_req_i = 4'b1111;
    look(); chk("trigger_gnt", bus.up_gnt_o, 4'b0100); chk("trigger_locked", locked_o, 1);
    nc();
    bus.up_req_i = 4'b1011;
    look(); chk("unlock_locked", locked_o, 0); chk("unlock_gnt", bus.up_gnt_o, 4'b1000);
    nc(); quiet();

    // failed acquire leaves round-robin running
    lock_by(1, 32'hFFFF_FFFF);
    for (int k = 0; k < N; k++) put(k, 1'b1, 3);
    bus.up_req_i = 4'b1111;
    look(); chk("nack_locked", locked_o, 0); chk("nack_gnt", bus.up_gnt_o, 4'b0100);
    nc(); look(); chk("nack_gnt2", bus.up_gnt_o, 4'b1000);
    nc(); quiet();

    // silent owner times out after LT idle cycles
    lock_by(0, 32'h0);
    for (int k = 1; k < N; k++) put(k, 1'b1, 3);
    bus.up_req_i = 4'b1110;
    for (int c = 1; c <= LT; c++) begin
      look();
      chk("to_locked", locked_o, 1); chk("to_pulse_early", timeout_o, 0); chk("to_gnt_blocked", bus.up_gnt_o, 0);
      nc();
    end
    look(); chk("to_pulse", timeout_o, 1); chk("to_unlocked", locked_o, 0); chk("to_gnt", bus.up_gnt_o, 4'b0010);
    nc(); look(); chk("to_pulse_end", timeout_o, 0);
    nc(); quiet();

    // asynchronous reset while locked
    lock_by(3, 32'h0);
    for (int k = 0; k < N; k++) put(k, 1'b1, 3);
    bus.up_req_i = 4'b1111; bus.slv_r_valid_i = 1'b1;
    look(); chk("ar_owner_gnt", bus.up_gnt_o, 4'b1000);
    #1 rst_i = 1'b1;
    #1;
    chk("ar_gnt", bus.up_gnt_o, 0); chk("ar_slv_req", bus.slv_req_o, 0);
    chk("ar_rvalid", bus.up_r_valid_o, 0); chk("ar_locked", locked_o, 0);
    chk("ar_owner", lock_owner_o, 0); chk("ar_timeout", timeout_o, 0);
    nc(); nc();
    rst_i = 1'b0; bus.slv_r_valid_i = 1'b0;
    look(); chk("ar_first_gnt", bus.up_gnt_o, 4'b0001);
    nc(); quiet();

    // clear while locked with a response in flight
    lock_by(2, 32'h0);
    put(2, 1'b1, 3); bus.up_req_i = 4'b0100; clear_i = 1'b1;
    look(); chk("clr_gnt", bus.up_gnt_o, 4'b0100); chk("clr_locked_before", locked_o, 1);
    nc();
    clear_i = 1'b0;
    for (int k = 0; k < N; k++) put(k, 1'b1, 3);
    bus.up_req_i = 4'b1111; bus.slv_r_valid_i = 1'b1;
    bus.slv_r_data_i = $urandom; bus.slv_r_id_i = 16'h5A5A;
    look();
    chk("clr_rvalid", bus.up_r_valid_o, 4'b0100); chk("clr_rid", bus.up_r_id_o, 16'h5A5A);
    chk("clr_locked", locked_o, 0); chk("clr_ptr_gnt", bus.up_gnt_o, 4'b0001);
    nc(); quiet();

    // randomized traffic with an auto-responding slave
    for (int c = 0; c < 3000; c++) begin
      nc();
      bus.slv_r_valid_i = pend;
      bus.slv_r_data_i  = $urandom;
      bus.slv_r_id_i    = 16'($urandom);
      for (int k = 0; k < N; k++) begin
        sel  = $urandom_range(0, 7);
        ridx = (sel == 0) ? 0 : (sel <= 3) ? 1 : (sel == 4) ? $urandom_range(0, NREGS - 1) : 3;
        rwen = (ridx == 0 && $urandom_range(0, 1) == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        put(k, rwen, ridx);
        if ((c / 100) % 3 == 2) bus.up_req_i[k] = ($urandom_range(0, 7) == 0);
        else                    bus.up_req_i[k] = ($urandom_range(0, 1) == 0);
      end
      bus.slv_gnt_i = ($urandom_range(0, 3) != 0);
      clear_i       = ($urandom_range(0, 63) == 0);
      look();
      pend = bus.slv_req_o & bus.slv_gnt_i;
    end
    nc(); quiet();
    nc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
